// File: rtl/accel_arbiter.sv
// Round-robin arbiter that shares one accelerator among four requesters.
// Handles one operation at a time, with a timeout while waiting for acc_done.
module accel_arbiter #(
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] req_data,
    output logic [3:0]     ack,
    output logic           acc_start,
    output logic [W-1:0]   acc_x,
    input  logic           acc_done,
    input  logic [W-1:0]   acc_result,
    output logic           resp_valid,
    output logic [1:0]     resp_id,
    output logic [W-1:0]   resp_data,
    output logic           resp_err,
    output logic           busy
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [1:0] gnt_id;
    logic [7:0] cnt;
    logic [1:0] sel_id;
    logic       sel_vld;
    logic [1:0] idx;
    logic       timeout_hit;

    // Grant search starts at ptr and wraps modulo 4.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = ptr;
        idx     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!sel_vld && req[idx]) begin
                sel_vld = 1'b1;
                sel_id  = idx;
            end
        end
    end

    assign timeout_hit = (cnt == TO_LIMIT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_vld) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (acc_done || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_id    <= '0;
            cnt       <= '0;
            acc_x     <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gnt_id <= sel_id;
                        acc_x  <= req_data[int'(sel_id)*W +: W];
                        ptr    <= sel_id + 2'd1;
                    end
                end
                LAUNCH: cnt <= '0;
                WAIT: begin
                    // acc_done takes priority over a simultaneous timeout
                    if (acc_done) begin
                        resp_data <= acc_result;
                        resp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_start  = (state == LAUNCH);
    assign ack        = (state == LAUNCH) ? (4'b0001 << gnt_id) : '0;
    assign resp_valid = (state == RESP);
    assign resp_id    = gnt_id;
    assign busy       = (state != IDLE);

    a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
    a_ack_start:  assert property (@(posedge clk) disable iff (rst) (ack != '0) == acc_start);
    a_cnt_range:  assert property (@(posedge clk) disable iff (rst) cnt <= TO_LIMIT);

endmodule

// File: tb/tb_accel_arbiter.sv
// Directed bench for accel_arbiter: reset, latency, round-robin order,
// timeout, done/timeout collision, stray done and mid-operation reset.
module tb_accel_arbiter;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] req_data;
    logic [3:0]     ack;
    logic           acc_start;
    logic [W-1:0]   acc_x;
    logic           acc_done;
    logic [W-1:0]   acc_result;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_data;
    logic           resp_err;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] slice_val [4] = '{16'h1234, 16'h2222, 16'h3333, 16'h4444};

    accel_arbiter #(.W(W), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .acc_start  (acc_start),
        .acc_x      (acc_x),
        .acc_done   (acc_done),
        .acc_result (acc_result),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation from an IDLE cycle: done in the first WAIT cycle.
    task automatic do_grant(input logic [3:0] r, input logic [1:0] exp_id, input string tag);
        logic [W-1:0] res;
        res = 16'hA000 | 16'(exp_id);
        req = r;
        tick();
        check({tag, "_ack"}, 32'(ack), 32'(4'b0001 << exp_id));
        check({tag, "_start"}, 32'(acc_start), 32'd1);
        check({tag, "_accx"}, 32'(acc_x), 32'(slice_val[exp_id]));
        tick();
        acc_done   = 1'b1;
        acc_result = res;
        tick();
        acc_done = 1'b0;
        check({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
        check({tag, "_rid"}, 32'(resp_id), 32'(exp_id));
        check({tag, "_rdata"}, 32'(resp_data), 32'(res));
        tick();
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic seen;
        rst        = 1'b1;
        req        = '0;
        acc_done   = 1'b0;
        acc_result = '0;
        req_data   = {slice_val[3], slice_val[2], slice_val[1], slice_val[0]};
        #12;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_start", 32'(acc_start), 32'd0);
        check("rst_accx", 32'(acc_x), 32'd0);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rid", 32'(resp_id), 32'd0);
        check("rst_rdata", 32'(resp_data), 32'd0);
        check("rst_rerr", 32'(resp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;

        // Stray done in IDLE
        acc_done   = 1'b1;
        acc_result = 16'hDEAD;
        tick();
        tick();
        acc_done = 1'b0;
        check("stray_rvalid", 32'(resp_valid), 32'd0);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_rdata", 32'(resp_data), 32'd0);

        // Round-robin with all requests held
        do_grant(4'b1111, 2'd0, "rr0");
        do_grant(4'b1111, 2'd1, "rr1");
        do_grant(4'b1111, 2'd2, "rr2");
        do_grant(4'b1111, 2'd3, "rr3");
        do_grant(4'b1111, 2'd0, "rr4");
        req = '0;

        // Single request, done after 3 WAIT cycles
        req = 4'b0001;
        tick();
        check("single_ack", 32'(ack), 32'b0001);
        check("single_start", 32'(acc_start), 32'd1);
        check("single_accx", 32'(acc_x), 32'h1234);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single_wait", 32'(resp_valid), 32'd0);
            check("single_start_off", 32'(acc_start), 32'd0);
        end
        tick();
        acc_done   = 1'b1;
        acc_result = 16'hABCD;
        tick();
        acc_done = 1'b0;
        check("single_rvalid", 32'(resp_valid), 32'd1);
        check("single_rid", 32'(resp_id), 32'd0);
        check("single_rdata", 32'(resp_data), 32'hABCD);
        check("single_rerr", 32'(resp_err), 32'd0);
        tick();
        check("single_hold", 32'(resp_data), 32'hABCD);
        check("single_rvalid_off", 32'(resp_valid), 32'd0);

        // Grant to 2 then req=1011 gives 3 then 0
        do_grant(4'b0100, 2'd2, "g2");
        do_grant(4'b1011, 2'd3, "g3");
        do_grant(4'b1011, 2'd0, "g0");
        req = '0;

        // Timeout: ptr is 1
        req = 4'b0010;
        tick();
        check("to_ack", 32'(ack), 32'b0010);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("to_wait", 32'(resp_valid), 32'd0);
            check("to_busy", 32'(busy), 32'd1);
        end
        tick();
        check("to_rvalid", 32'(resp_valid), 32'd1);
        check("to_rerr", 32'(resp_err), 32'd1);
        check("to_rdata", 32'(resp_data), 32'd0);
        check("to_rid", 32'(resp_id), 32'd1);
        tick();

        // Collision at cnt == TIMEOUT: ptr is 2
        req = 4'b0100;
        tick();
        check("col_ack", 32'(ack), 32'b0100);
        req = '0;
        for (int i = 0; i < 4; i++) tick();
        check("col_wait", 32'(resp_valid), 32'd0);
        tick();
        acc_done   = 1'b1;
        acc_result = 16'h5A5A;
        tick();
        acc_done = 1'b0;
        check("col_rvalid", 32'(resp_valid), 32'd1);
        check("col_rerr", 32'(resp_err), 32'd0);
        check("col_rdata", 32'(resp_data), 32'h5A5A);
        tick();

        // Reset during WAIT: ptr is 3
        req = 4'b1000;
        tick();
        check("rw_ack", 32'(ack), 32'b1000);
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_accx", 32'(acc_x), 32'd0);
        check("rw_rid", 32'(resp_id), 32'd0);
        tick();
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        check("rw_no_resp", 32'(seen), 32'd0);
        do_grant(4'b1111, 2'd0, "rw_next");
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accel_arbiter.md
ACCEL_ARBITER -- requirements
Module: accel_arbiter

Interface
REQ-001 Parameter W, default 16: operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles without acc_done; legal range 1..255; held in an 8-bit counter.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  4  per-requester request; bit i belongs to requester i.
REQ-006 req_data  input  4*W  operands; requester i occupies bits i*W+W-1 down to i*W.
REQ-007 ack  output  4  one-hot, one-cycle pulse to the requester whose operand was accepted.
REQ-008 acc_start  output  1  one-cycle start pulse to the shared accelerator.
REQ-009 acc_x  output  W  registered operand to the accelerator; stable from LAUNCH until the next grant.
REQ-010 acc_done  input  1  accelerator completion pulse.
REQ-011 acc_result  input  W  accelerator result; valid while acc_done=1.
REQ-012 resp_valid  output  1  one-cycle response pulse.
REQ-013 resp_id  output  2  index of the requester that owns the response.
REQ-014 resp_data  output  W  result returned to the requester.
REQ-015 resp_err  output  1  1 = response caused by timeout.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if req != 0, go to LAUNCH; otherwise stay in IDLE.
- LAUNCH: always go to WAIT.
- WAIT: if acc_done, go to RESP; else if cnt == TIMEOUT, go to RESP with error; else stay in WAIT.
- RESP: always go to IDLE.
REQ-018 Round-robin arbitration:
- Pointer ptr (2 bits) resets to 0.
- In IDLE, the grant is the first asserted req bit searching ptr, ptr+1, ... with wrap-around modulo 4.
- At the same edge that leaves IDLE: gnt_id is registered, acc_x captures that requester's req_data slice, and ptr becomes gnt_id+1 mod 4 (3 wraps to 0).
REQ-019 In LAUNCH, acc_start=1 and ack[gnt_id]=1 for exactly that one cycle; cnt is cleared to 0.
REQ-020 Latency: req sampled in IDLE at edge k gives acc_start/ack in cycle k+1; the earliest response is cycle k+3 (acc_done in the first WAIT cycle).
REQ-021 In WAIT, cnt increments by 1 each cycle without acc_done; WAIT lasts at most TIMEOUT+1 cycles.
REQ-022 acc_done in WAIT: resp_data captures acc_result, resp_err=0.
REQ-023 Timeout (cnt == TIMEOUT without acc_done): resp_data=0, resp_err=1.
REQ-024 acc_done and the timeout condition in the same cycle: acc_done wins, resp_err=0.
REQ-025 In RESP, resp_valid=1 for one cycle with resp_id=gnt_id; resp_data and resp_err hold their values until the next RESP.
REQ-026 acc_done in IDLE, LAUNCH or RESP SHALL be ignored: no state change and no capture.
REQ-027 Requesters drop req the cycle after ack; a req bit still high when the FSM returns to IDLE is treated as a new request.
REQ-028 A req bit that is withdrawn before it is granted is simply not considered; it causes no error.
REQ-029 At most one operation is outstanding; req changes outside IDLE have no effect.

Reset
REQ-030 On rst=1, immediately and asynchronously:
- state=IDLE, ptr=0, cnt=0, gnt_id=0.
- all outputs=0: ack, acc_start, acc_x, resp_valid, resp_id, resp_data, resp_err, busy.
REQ-031 Reset during LAUNCH, WAIT or RESP aborts the operation; no resp_valid is produced for it, and arbitration restarts from ptr=0.

Verification
REQ-032 The bench SHALL cover these scenarios:
- Single request: req=0001, data 0x1234; acc_done after 3 WAIT cycles with result 0xABCD. Expect ack=0001 and acc_start together one cycle after the request, acc_x=0x1234, then resp_valid with resp_id=0, resp_data=0xABCD, resp_err=0.
- Round-robin: req=1111 held and re-asserted after each response. Expect grants in order 0,1,2,3,0.
- Round-robin after a grant to 2: req=1011. Expect the next grant to 3, then 0.
- Timeout: TIMEOUT=4 and acc_done never asserted. Expect resp_valid exactly 5 WAIT cycles after LAUNCH, resp_err=1, resp_data=0.
- Collision: acc_done=1 in the cycle where cnt == TIMEOUT. Expect resp_err=0 and resp_data=acc_result.
- Stray done and reset: acc_done pulse in IDLE gives no response. rst asserted in WAIT: busy=0 immediately, no resp_valid follows, and the next grant with req=1111 goes to 0.
